// File: rtl/cfg_axil_cmd_master_if.sv
// AXI-lite bus between cfg_axil_cmd_master and the register memory slave.
//
// Channels:
//   AW : awvalid, awready, awaddr, awid
//   W  : wvalid, wready, wdata
//   B  : bvalid, bready, bresp, bid
//   AR : arvalid, arready, araddr, arid
//   R  : rvalid, rready, rdata, rresp, rid, rlast
//
// Modports:
//   master : the command master (drives valids on AW/W/AR, readys on B/R)
//   slave  : the register memory slave (mirror image)
interface cfg_axil_cmd_master_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int ID_SIZE   = 32
);
  logic                 awvalid;
  logic                 awready;
  logic [ADDR_SIZE-1:0] awaddr;
  logic [ID_SIZE-1:0]   awid;

  logic                 wvalid;
  logic                 wready;
  logic [DATA_SIZE-1:0] wdata;

  logic                 bvalid;
  logic                 bready;
  logic [1:0]           bresp;
  logic [ID_SIZE-1:0]   bid;

  logic                 arvalid;
  logic                 arready;
  logic [ADDR_SIZE-1:0] araddr;
  logic [ID_SIZE-1:0]   arid;

  logic                 rvalid;
  logic                 rready;
  logic [DATA_SIZE-1:0] rdata;
  logic [1:0]           rresp;
  logic [ID_SIZE-1:0]   rid;
  logic                 rlast;

  modport master (
    output awvalid, awaddr, awid,
    input  awready,
    output wvalid, wdata,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid,
    output awready,
    input  wvalid, wdata,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready
  );
endinterface

// File: rtl/cfg_axil_cmd_master.sv
// Configuration command master: turns one command at a time into a single
// AXI-lite write (AW+W -> B) or read (AR -> R) and returns the outcome on a
// response stream. A watchdog counter bounds every transaction so a hung
// slave cannot lock the config path.
//
// Ports:
//   clk, reset_n      : clock (rising edge), asynchronous active-low reset
//   cmd_*             : command stream in (valid/ready, write, addr, wdata, id)
//   rsp_*             : response stream out (valid/ready, write, id, rdata, resp)
//   axi               : AXI-lite master side (cfg_axil_cmd_master_if.master)
//   dbg_state         : current FSM state encoding (state_t)
//
// Handshake rule, for every valid/ready pair here: a transfer happens on a
// rising edge where valid and ready are both high; a producer never drops
// valid, nor changes the payload, until that transfer; a consumer may raise
// or lower ready freely.
//
// rsp_resp: 2'b00 OKAY, 2'b10 SLVERR (from slave), 2'b11 local timeout.
//
// Timeout: the counter is 0 in the first cycle the address valid is up and
// counts up every cycle of the transaction. TIMEOUT cycles are allowed for the
// response handshake; if the cycle with count TIMEOUT-1 passes without it, the
// transaction is abandoned. A matching response in that last cycle still wins.
// TIMEOUT must be at least 2.
module cfg_axil_cmd_master #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int ID_SIZE   = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [DATA_SIZE-1:0] cmd_wdata,
  input  logic [ID_SIZE-1:0]   cmd_id,

  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [ID_SIZE-1:0]   rsp_id,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic [1:0]           rsp_resp,

  cfg_axil_cmd_master_if.master axi,

  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_WAIT_B = 3'd2,
    S_RD     = 3'd3,
    S_WAIT_R = 3'd4,
    S_RSP    = 3'd5
  } state_t;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ID_SIZE-1:0] id_q;
  logic               write_q;
  logic               expired;
  logic               aw_left;
  logic               w_left;

  // rlast carries no information for single-beat AXI-lite reads.
  logic unused_rlast;
  assign unused_rlast = axi.rlast;

  assign dbg_state = state;
  assign expired   = (cnt == CNT_W'(TIMEOUT - 1));
  // A channel still owes a handshake if its valid is up and ready is low.
  assign aw_left   = axi.awvalid && !axi.awready;
  assign w_left    = axi.wvalid && !axi.wready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      id_q        <= '0;
      write_q     <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_id      <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.awid    <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.arid    <= '0;
      // B and R readys stay high at all times so stray or late responses
      // are always sunk rather than stalling the slave.
      axi.bready  <= 1'b1;
      axi.rready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            id_q      <= cmd_id;
            write_q   <= cmd_write;
            cnt       <= '0;
            if (cmd_write) begin
              axi.awvalid <= 1'b1;
              axi.awaddr  <= cmd_addr;
              axi.awid    <= cmd_id;
              axi.wvalid  <= 1'b1;
              axi.wdata   <= cmd_wdata;
              state       <= S_WR;
            end else begin
              axi.arvalid <= 1'b1;
              axi.araddr  <= cmd_addr;
              axi.arid    <= cmd_id;
              state       <= S_RD;
            end
          end
        end

        S_WR: begin
          cnt <= cnt + CNT_W'(1);
          if (expired) begin
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= write_q;
            rsp_id      <= id_q;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_TIMEOUT;
            state       <= S_RSP;
          end else begin
            // AW and W complete independently, in either order.
            if (axi.awready) axi.awvalid <= 1'b0;
            if (axi.wready)  axi.wvalid  <= 1'b0;
            if (!aw_left && !w_left) state <= S_WAIT_B;
          end
        end

        S_WAIT_B: begin
          cnt <= cnt + CNT_W'(1);
          if (axi.bvalid && (axi.bid == id_q)) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_id    <= id_q;
            rsp_rdata <= '0;
            rsp_resp  <= axi.bresp;
            state     <= S_RSP;
          end else if (expired) begin
            rsp_valid <= 1'b1;
            rsp_write <= write_q;
            rsp_id    <= id_q;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_TIMEOUT;
            state     <= S_RSP;
          end
          // A B beat with a foreign id is consumed (bready high) and ignored.
        end

        S_RD: begin
          cnt <= cnt + CNT_W'(1);
          if (expired) begin
            axi.arvalid <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= write_q;
            rsp_id      <= id_q;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_TIMEOUT;
            state       <= S_RSP;
          end else if (axi.arready) begin
            axi.arvalid <= 1'b0;
            state       <= S_WAIT_R;
          end
        end

        S_WAIT_R: begin
          cnt <= cnt + CNT_W'(1);
          if (axi.rvalid && (axi.rid == id_q)) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_id    <= id_q;
            rsp_rdata <= axi.rdata;
            rsp_resp  <= axi.rresp;
            state     <= S_RSP;
          end else if (expired) begin
            rsp_valid <= 1'b1;
            rsp_write <= write_q;
            rsp_id    <= id_q;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_TIMEOUT;
            state     <= S_RSP;
          end
        end

        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            // Ready for the next command straight away.
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_axil_cmd_master.sv
module tb_cfg_axil_cmd_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int TO = 16;
  localparam int EW = 1 + IW + DW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [IW-1:0] cmd_id    = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [IW-1:0] rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [2:0]    dbg_state;

  cfg_axil_cmd_master_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .ID_SIZE(IW)) bus ();

  cfg_axil_cmd_master #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .ID_SIZE(IW), .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_id    (cmd_id),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .axi       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- slave model knobs ----------------
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_delay = 0, r_delay = 0;
  bit          b_wrong_first = 1'b0, r_never = 1'b0;
  logic [1:0]  b_resp_k = 2'b00, r_resp_k = 2'b00;
  logic [DW-1:0] r_data_k = '0;
  int          b_count = 0, r_count = 0;

  // Slave: acts 1 time unit after each edge, seeing the DUT outputs that the
  // edge produced; its *_pend flags record a transfer due at the next edge.
  initial begin : slave
    int aw_cyc, w_cyc, ar_cyc, bd_cnt, rd_cnt;
    bit aw_pend, w_pend, ar_pend, b_pend, r_pend;
    bit aw_done, w_done, ar_done, wrong_sent;
    logic [IW-1:0] s_wid, s_rid;
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0; bd_cnt = 0; rd_cnt = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
    aw_done = 0; w_done = 0; ar_done = 0; wrong_sent = 0;
    s_wid = '0; s_rid = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.bid = '0; bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    bus.rresp = 2'b00; bus.rid = '0; bus.rlast = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.rvalid = 1'b0;
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0; bd_cnt = 0; rd_cnt = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
        aw_done = 0; w_done = 0; ar_done = 0; wrong_sent = 0;
      end else begin
        if (aw_pend) aw_done = 1;
        if (w_pend)  w_done = 1;
        if (ar_pend) ar_done = 1;
        if (b_pend) begin
          bus.bvalid = 1'b0;
          if (b_wrong_first && !wrong_sent) wrong_sent = 1;
          else begin
            b_count++; aw_done = 0; w_done = 0; bd_cnt = 0; wrong_sent = 0;
          end
        end
        if (r_pend) begin
          bus.rvalid = 1'b0; r_count++; ar_done = 0; rd_cnt = 0;
        end
        bus.awready = bus.awvalid && (aw_cyc >= aw_wait);
        aw_cyc = bus.awvalid ? aw_cyc + 1 : 0;
        if (bus.awvalid) s_wid = bus.awid;
        bus.wready = bus.wvalid && (w_cyc >= w_wait);
        w_cyc = bus.wvalid ? w_cyc + 1 : 0;
        bus.arready = bus.arvalid && (ar_cyc >= ar_wait);
        ar_cyc = bus.arvalid ? ar_cyc + 1 : 0;
        if (bus.arvalid) s_rid = bus.arid;
        if (aw_done && w_done && !bus.bvalid) begin
          if (bd_cnt >= b_delay) begin
            bus.bvalid = 1'b1;
            bus.bresp  = b_resp_k;
            bus.bid    = (b_wrong_first && !wrong_sent) ? (s_wid ^ 32'h1) : s_wid;
          end else bd_cnt++;
        end
        if (ar_done && !bus.rvalid && !r_never) begin
          if (rd_cnt >= r_delay) begin
            bus.rvalid = 1'b1; bus.rdata = r_data_k; bus.rresp = r_resp_k;
            bus.rid = s_rid; bus.rlast = 1'b1;
          end else rd_cnt++;
        end
        aw_pend = bus.awvalid && bus.awready;
        w_pend  = bus.wvalid && bus.wready;
        ar_pend = bus.arvalid && bus.arready;
        b_pend  = bus.bvalid && bus.bready;
        r_pend  = bus.rvalid && bus.rready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Returns one cycle after the command handshake edge.
  task automatic issue_cmd(input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [IW-1:0] id);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_id = id;
    while (cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_accept cmd_ready=%b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cyc, output int n, output bit got);
    n = 0;
    while (rsp_valid !== 1'b1 && n < max_cyc) begin tick(); n++; end
    got = (rsp_valid === 1'b1);
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  function automatic logic [EW-1:0] obs_rsp();
    return {rsp_write, rsp_id, rsp_rdata, rsp_resp};
  endfunction

  function automatic logic [EW-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({cmd_ready, bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid, bus.bready, bus.rready} !== 7'b0000011) begin
      errors++; $display("FAIL reset_ctrl got %b required 0000011",
        {cmd_ready, bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid, bus.bready, bus.rready});
    end
    checks++;
    if ({dbg_state, rsp_resp, rsp_id, bus.awaddr} !== '0) begin
      errors++; $display("FAIL reset_data state=%0d resp=%b id=%h awaddr=%h required 0",
        dbg_state, rsp_resp, rsp_id, bus.awaddr);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int n; bit got; logic [EW-1:0] e;
    aw_wait = 0; w_wait = 0; b_delay = 0; b_resp_k = 2'b00;
    exp_q.push_back({1'b1, 32'd7, 32'd0, 2'b00});
    issue_cmd(1'b1, 32'd3005, 32'hDEADBEEF, 32'd7);
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.arvalid} !== 3'b110) begin
      errors++; $display("FAIL wr_valid_n1 got %b required 110", {bus.awvalid, bus.wvalid, bus.arvalid});
    end
    checks++;
    if ({bus.awaddr, bus.awid, bus.wdata} !== {32'd3005, 32'd7, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_payload got %h %h %h required bbd 7 deadbeef", bus.awaddr, bus.awid, bus.wdata);
    end
    wait_rsp(10, n, got);
    checks++;
    if (!got || n != 2) begin
      errors++; $display("FAIL wr_rsp_latency got=%0d cycles=%0d required 2", got, n);
    end
    e = pop_exp();
    checks++;
    if (obs_rsp() !== e) begin
      errors++; $display("FAIL wr_rsp got %h required %h", obs_rsp(), e);
    end
    consume_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr_drain rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read();
    int n; bit got; logic [EW-1:0] e;
    ar_wait = 0; r_delay = 0; r_data_k = 32'h12345678; r_resp_k = 2'b00;
    exp_q.push_back({1'b0, 32'd3, 32'h12345678, 2'b00});
    issue_cmd(1'b0, 32'd4010, 32'hFFFF_FFFF, 32'd3);
    checks++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.araddr, bus.arid} !== {3'b100, 32'd4010, 32'd3}) begin
      errors++; $display("FAIL rd_ar_n1 got %b %h %h required 100 faa 3",
        {bus.arvalid, bus.awvalid, bus.wvalid}, bus.araddr, bus.arid);
    end
    wait_rsp(10, n, got);
    checks++;
    if (!got || n != 2) begin
      errors++; $display("FAIL rd_rsp_latency got=%0d cycles=%0d required 2", got, n);
    end
    e = pop_exp();
    checks++;
    if (obs_rsp() !== e) begin
      errors++; $display("FAIL rd_rsp got %h required %h", obs_rsp(), e);
    end
    consume_rsp();
  endtask

  task automatic test_aw_delay();
    int n, awc, wc, bc0; bit got, unstable, stray; logic [EW-1:0] e;
    aw_wait = 3; w_wait = 0; b_delay = 0; b_resp_k = 2'b00;
    awc = 0; wc = 0; unstable = 0; stray = 0; bc0 = b_count;
    exp_q.push_back({1'b1, 32'd9, 32'd0, 2'b00});
    issue_cmd(1'b1, 32'h2000, 32'hA5A5_0001, 32'd9);
    for (int k = 0; k < 12 && (bus.awvalid === 1'b1 || bus.wvalid === 1'b1); k++) begin
      if (bus.awvalid === 1'b1) begin
        awc++;
        if (bus.awaddr !== 32'h2000 || bus.awid !== 32'd9) unstable = 1;
      end
      if (bus.wvalid === 1'b1) wc++;
      tick();
    end
    checks++;
    if (awc != 4 || wc != 1) begin
      errors++; $display("FAIL awdelay_valid_len aw=%0d w=%0d required 4 1", awc, wc);
    end
    checks++;
    if (unstable) begin
      errors++; $display("FAIL awdelay_stable awaddr changed while awvalid, required stable 2000");
    end
    wait_rsp(10, n, got);
    e = pop_exp();
    checks++;
    if (!got || obs_rsp() !== e) begin
      errors++; $display("FAIL awdelay_rsp got=%0d %h required %h", got, obs_rsp(), e);
    end
    consume_rsp();
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid !== 1'b0) stray = 1;
      tick();
    end
    checks++;
    if (stray || (b_count - bc0) != 1) begin
      errors++; $display("FAIL awdelay_single stray=%0d b_beats=%0d required 0 1", stray, b_count - bc0);
    end
  endtask

  task automatic test_rsp_backpressure();
    int n; bit got, bad; logic [EW-1:0] e;
    ar_wait = 0; r_delay = 0; r_data_k = 32'd0; r_resp_k = 2'b10;
    exp_q.push_back({1'b0, 32'd4, 32'd0, 2'b10});
    issue_cmd(1'b0, 32'd100, 32'd0, 32'd4);
    wait_rsp(10, n, got);
    e = pop_exp();
    checks++;
    if (!got || obs_rsp() !== e) begin
      errors++; $display("FAIL bp_rsp got=%0d %h required %h", got, obs_rsp(), e);
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid !== 1'b1 || obs_rsp() !== e || cmd_ready !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bp_hold got valid=%b rsp=%h cmd_ready=%b required 1 %h 0",
        rsp_valid, obs_rsp(), cmd_ready, e);
    end
    consume_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_drain rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_timeout();
    int n, bc0; bit got, seen, stray, not_ready; logic [EW-1:0] e;
    aw_wait = 0; w_wait = 0; b_delay = 20; b_resp_k = 2'b00;
    exp_q.push_back({1'b1, 32'h11, 32'd0, 2'b11});
    issue_cmd(1'b1, 32'h3000, 32'h0BAD_F00D, 32'h11);
    wait_rsp(40, n, got);
    checks++;
    if (!got || n != TO) begin
      errors++; $display("FAIL timeout_latency got=%0d cycles=%0d required %0d", got, n, TO);
    end
    e = pop_exp();
    checks++;
    if (obs_rsp() !== e) begin
      errors++; $display("FAIL timeout_rsp got %h required %h", obs_rsp(), e);
    end
    consume_rsp();
    bc0 = b_count; seen = 0; stray = 0; not_ready = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.bvalid === 1'b1) begin
        seen = 1;
        if (bus.bready !== 1'b1) not_ready = 1;
      end
      if (rsp_valid !== 1'b0) stray = 1;
      tick();
    end
    checks++;
    if (!seen || not_ready || (b_count - bc0) != 1) begin
      errors++; $display("FAIL late_b_absorb seen=%0d bready_low=%0d beats=%0d required 1 0 1",
        seen, not_ready, b_count - bc0);
    end
    checks++;
    if (stray || dbg_state !== 3'd0) begin
      errors++; $display("FAIL late_b_no_rsp stray=%0d state=%0d required 0 0", stray, dbg_state);
    end
    b_delay = 0;
  endtask

  task automatic test_wrong_bid();
    int n; bit got; logic [EW-1:0] e;
    aw_wait = 0; w_wait = 0; b_delay = 0; b_resp_k = 2'b10; b_wrong_first = 1'b1;
    exp_q.push_back({1'b1, 32'd5, 32'd0, 2'b10});
    issue_cmd(1'b1, 32'h3004, 32'h55, 32'd5);
    tick();
    tick();
    checks++;
    if (dbg_state !== 3'd2 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL wrong_bid_discard state=%0d rsp_valid=%b required 2 0", dbg_state, rsp_valid);
    end
    wait_rsp(10, n, got);
    e = pop_exp();
    checks++;
    if (!got || n != 1 || obs_rsp() !== e) begin
      errors++; $display("FAIL wrong_bid_rsp got=%0d cycles=%0d %h required 1 %h", got, n, obs_rsp(), e);
    end
    consume_rsp();
    b_wrong_first = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit stray;
    ar_wait = 0; r_never = 1'b1;
    issue_cmd(1'b0, 32'h10, 32'd0, 32'd6);
    tick();
    checks++;
    if (dbg_state !== 3'd4) begin
      errors++; $display("FAIL rst_mid_wait_r state=%0d required 4", dbg_state);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid, bus.bready, bus.rready} !== 7'b0000011
        || dbg_state !== 3'd0 || bus.araddr !== '0 || bus.arid !== '0 || rsp_id !== '0) begin
      errors++; $display("FAIL rst_mid_outputs ctrl=%b state=%0d araddr=%h arid=%h required 0000011 0 0 0",
        {cmd_ready, bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid, bus.bready, bus.rready},
        dbg_state, bus.araddr, bus.arid);
    end
    tick();
    tick();
    reset_n = 1'b1;
    r_never = 1'b0;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rsp_valid !== 1'b0) stray = 1;
    end
    checks++;
    if (stray || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_no_rsp stray=%0d cmd_ready=%b required 0 1", stray, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit got; logic wr; logic [IW-1:0] id; logic [DW-1:0] rd; logic [1:0] rs;
    logic [EW-1:0] e;
    for (int i = 0; i < 8; i++) begin
      wr = 1'($urandom_range(0, 1));
      id = 32'($urandom_range(0, 255));
      rd = $urandom;
      rs = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
      aw_wait = $urandom_range(0, 2); w_wait = $urandom_range(0, 2);
      ar_wait = $urandom_range(0, 2); b_delay = $urandom_range(0, 2);
      r_delay = $urandom_range(0, 2);
      b_resp_k = rs; r_resp_k = rs; r_data_k = rd;
      exp_q.push_back({wr, id, wr ? 32'd0 : rd, rs});
      issue_cmd(wr, $urandom, $urandom, id);
      wait_rsp(TO + 4, n, got);
      e = pop_exp();
      checks++;
      if (!got || obs_rsp() !== e) begin
        errors++; $display("FAIL b2b_rsp[%0d] got=%0d %h required %h", i, got, obs_rsp(), e);
      end
      for (int k = $urandom_range(0, 2); k > 0; k--) tick();
      consume_rsp();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_write();
    test_read();
    test_aw_delay();
    test_rsp_backpressure();
    test_timeout();
    test_wrong_bid();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty left=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_axil_cmd_master.md
Name: cfg_axil_cmd_master

Overview:
- Upstream AXI-lite master feeding the register memory slave (output_port, crc_mem and connection_config_mem regions).
- Accepts one configuration command at a time over a valid/ready command stream and issues a single AXI-lite write (AW+W → B) or read (AR → R).
- Returns the outcome on a valid/ready response stream.
- Watchdogs each transaction with a timeout counter so a hung slave cannot lock the config path.

Parameters:
- DATA_SIZE, 32, width of write/read data.
- ADDR_SIZE, 32, width of AXI address.
- ID_SIZE, 32, width of transaction IDs.
- TIMEOUT, 1024, cycles allowed from first address-channel valid to response handshake; minimum 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_SIZE  target address.
- cmd_wdata  in  DATA_SIZE  write data (ignored for reads).
- cmd_id  in  ID_SIZE  transaction ID.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_id  out  ID_SIZE  echo of cmd_id.
- rsp_rdata  out  DATA_SIZE  read data; 0 for writes or timeout.
- rsp_resp  out  2  AXI resp (00 OKAY, 10 SLVERR, 11 local timeout).
- awvalid/awready/awaddr/awid  out/in/out/out  1/1/ADDR_SIZE/ID_SIZE  write address channel.
- wvalid/wready/wdata  out/in/out  1/1/DATA_SIZE  write data channel.
- bvalid/bready/bresp/bid  in/out/in/in  1/1/2/ID_SIZE  write response channel.
- arvalid/arready/araddr/arid  out/in/out/out  1/1/ADDR_SIZE/ID_SIZE  read address channel.
- rvalid/rready/rdata/rresp/rid/rlast  in/out/in/in/in/in  1/1/DATA_SIZE/2/ID_SIZE/1  read data channel; rlast ignored.

Behaviour:
- Reset (async assert, sync deassert release):
  - All valids low; cmd_ready = 0; bready = rready = 1 (drain).
  - Output data/addr/id/resp = 0; state IDLE; timeout counter 0.
- States:
  - IDLE: cmd_ready = 1.
    - On cmd handshake, register addr/data/id/write.
    - Write → WR; read → RD.
  - WR: awvalid and wvalid both rise in the cycle after the cmd handshake.
    - Each drops independently on its own handshake, in either order or the same cycle.
    - Once both handshakes are complete → WAIT_B.
  - WAIT_B: bready = 1.
    - On bvalid with bid == stored id: capture bresp → RSP.
    - On bvalid with bid != stored id: consume and discard; stay in WAIT_B.
  - RD: arvalid rises in the cycle after the cmd handshake; drops on arready → WAIT_R.
  - WAIT_R: rready = 1.
    - On rvalid with matching rid: capture rdata/rresp → RSP.
    - Mismatched rid: discard and stay.
  - RSP: rsp_valid = 1 with stable fields until rsp_ready, then → IDLE.
- Outside WAIT_B, WAIT_R and reset, bready and rready are held high so late or stray responses are sunk.
- Valids never drop before their handshake (AXI rule); addr/data/id remain stable while valid.
- Latency: with an always-ready slave, write cmd handshake at cycle N:
  - awvalid/wvalid at N+1.
  - bvalid earliest N+2.
  - rsp_valid at the cycle after the B handshake.
  - Read path is identical with AR/R.
- Timeout:
  - Counter clears on cmd handshake and increments each cycle in WR/WAIT_B/RD/WAIT_R.
  - On reaching TIMEOUT: drop any pending valids and go to RSP with rsp_resp = 11, rsp_rdata = 0.
  - A response arriving in the same cycle as expiry wins (real resp is reported).
- Only one outstanding transaction; cmd_ready = 0 in every state except IDLE.
- Reset asserted mid-transaction immediately clears all state; no response is emitted for the aborted command.

Test Plan:
- Write cmd addr 3005, data 0xDEADBEEF, id 7; slave ready always, bresp 00 → awvalid/wvalid at N+1, rsp_valid with resp 00, id 7, write 1.
- Read cmd addr 4010, id 3; slave returns rdata 0x12345678, rid 3, rresp 00 → rsp_rdata 0x12345678, resp 00, rsp_write 0.
- Write with awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr, one B accepted, one response.
- Read of unmapped addr 100, slave rresp 10; rsp_ready low 5 cycles → rsp fields stable 5 cycles, resp 10, cmd_ready stays 0 until drained.
- TIMEOUT = 16, slave never asserts bvalid → rsp_resp 11 at exactly 16 cycles after cmd accept; a late bvalid in IDLE is absorbed with bready = 1 and no extra response.
- Reset pulsed while in WAIT_R, plus a bvalid with wrong bid in WAIT_B → all outputs return to reset values with no rsp; the wrong-bid B is discarded and the FSM still waits for the matching bid.
